// File: rtl/wgt_tile_addr_gen.sv
// Weight-buffer address sequencer: walks every filter tile of the systolic array and
// emits DEPTH consecutive read addresses per tile, with stall, tile handshake and abort.
module wgt_tile_addr_gen #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int NO_CHANNEL    = 3,
  parameter int NO_FILTER     = 19,
  parameter int ADDR_WIDTH    = 11,
  parameter int SIZE_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  stall,
  input  logic                  next_tile,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] wgt_addr,
  output logic                  read_en,
  output logic [SIZE_WIDTH-1:0] size,
  output logic [ADDR_WIDTH-1:0] tile_idx,
  output logic                  tile_done,
  output logic                  done,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // Handshake: a read is transferred on every cycle where read_en is high; the
  // consumer lowers its ready by raising stall, which holds wgt_addr and k.
  localparam int DEPTH     = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
  localparam int NT        = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int LAST_SIZE = NO_FILTER - (NT - 1) * SYSTOLIC_SIZE;
  localparam int KW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [KW-1:0]         K_LAST     = KW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] TILE_LAST  = ADDR_WIDTH'(NT - 1);
  localparam logic [SIZE_WIDTH-1:0] FULL_SIZE  = SIZE_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [SIZE_WIDTH-1:0] TAIL_SIZE  = SIZE_WIDTH'(LAST_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    WAIT_TILE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [KW-1:0]           k;
  logic [ADDR_WIDTH-1:0]   tile_base;
  logic                    last_k;
  logic                    last_tile;

  assign last_k    = (k == K_LAST);
  assign last_tile = (tile_idx == TILE_LAST);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    read_en   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        read_en = ~stall;
        if (abort)                 state_nxt = IDLE;
        else if (!stall && last_k) state_nxt = last_tile ? DONE : WAIT_TILE;
      end
      WAIT_TILE: begin
        if (abort)          state_nxt = IDLE;
        else if (next_tile) state_nxt = READ;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tile_base accumulates DEPTH per tile so the next tile's first address is ready
  // without a multiplier; it wraps modulo 2^ADDR_WIDTH like wgt_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wgt_addr  <= '0;
      tile_base <= '0;
      k         <= '0;
      tile_idx  <= '0;
      size      <= '0;
      tile_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wgt_addr  <= base_addr;
            tile_base <= base_addr;
            k         <= '0;
            tile_idx  <= '0;
            size      <= (NT == 1) ? TAIL_SIZE : FULL_SIZE;
          end
        end
        READ: begin
          if (!abort && !stall) begin
            if (last_k) begin
              tile_base <= tile_base + DEPTH_A;
              tile_done <= 1'b1;
              done      <= last_tile;
            end else begin
              k        <= k + KW'(1);
              wgt_addr <= wgt_addr + ADDR_WIDTH'(1);
            end
          end
        end
        WAIT_TILE: begin
          if (!abort && next_tile) begin
            tile_idx <= tile_idx + ADDR_WIDTH'(1);
            k        <= '0;
            wgt_addr <= tile_base;
            size     <= ((tile_idx + ADDR_WIDTH'(1)) == TILE_LAST) ? TAIL_SIZE : FULL_SIZE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wgt_tile_addr_gen.sv
// Bench for wgt_tile_addr_gen: expected read/tile events are queued per pass from a
// plain arithmetic model and popped by a monitor whenever the DUT presents them.
module tb_wgt_tile_addr_gen;

  localparam int SS = 16, KS = 3, NC = 3, NF = 19, AW = 11, SW = 5;
  localparam int DEPTH = KS * KS * NC;
  localparam int NT    = (NF + SS - 1) / SS;
  localparam int EW    = AW + SW + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stall = 1'b0, next_tile = 1'b0, abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] wgt_addr, tile_idx;
  logic          read_en, tile_done, done, busy;
  logic [SW-1:0] size;
  logic [1:0]    state_dbg;

  logic          s_start = 1'b0, s_stall = 1'b0, s_next = 1'b0, s_abort = 1'b0;
  logic [AW-1:0] s_base = '0;
  logic [AW-1:0] s_addr, s_tile;
  logic          s_read_en, s_tile_done, s_done, s_busy;
  logic [SW-1:0] s_size;
  logic [1:0]    s_state;

  int  nchecks = 0;
  int  nerrors = 0;
  int  reads_seen = 0;
  bit  rand_en = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic          ev_q[$];

  always #5 clk = ~clk;

  wgt_tile_addr_gen #(.SYSTOLIC_SIZE(SS), .KERNEL_SIZE(KS), .NO_CHANNEL(NC),
                      .NO_FILTER(NF), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stall(stall),
    .next_tile(next_tile), .abort(abort), .wgt_addr(wgt_addr), .read_en(read_en),
    .size(size), .tile_idx(tile_idx), .tile_done(tile_done), .done(done),
    .busy(busy), .state_dbg(state_dbg)
  );

  wgt_tile_addr_gen #(.SYSTOLIC_SIZE(SS), .KERNEL_SIZE(KS), .NO_CHANNEL(NC),
                      .NO_FILTER(1), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut_one (
    .clk(clk), .rst(rst), .start(s_start), .base_addr(s_base), .stall(s_stall),
    .next_tile(s_next), .abort(s_abort), .wgt_addr(s_addr), .read_en(s_read_en),
    .size(s_size), .tile_idx(s_tile), .tile_done(s_tile_done), .done(s_done),
    .busy(s_busy), .state_dbg(s_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one full pass from the tile/size/address rules.
  task automatic push_pass(input int base);
    int sz;
    for (int t = 0; t < NT; t++) begin
      sz = (t == NT - 1) ? (NF - (NT - 1) * SS) : SS;
      for (int kk = 0; kk < DEPTH; kk++)
        exp_q.push_back({AW'(t), SW'(sz), AW'((base + t * DEPTH + kk) % (1 << AW))});
      ev_q.push_back(t == NT - 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (read_en) begin
        if (exp_q.size() == 0) chk("unexpected_read", {1'b1, wgt_addr}, 0);
        else chk("read", {tile_idx, size, wgt_addr}, exp_q.pop_front());
        reads_seen++;
      end
      if (tile_done || done) begin
        if (ev_q.size() == 0) chk("unexpected_tile_done", {tile_done, done}, 0);
        else chk("tile_done_done", {tile_done, done}, {1'b1, ev_q.pop_front()});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_en) begin
      stall     = ($urandom_range(0, 3) == 0);
      next_tile = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    base_addr = b;
    start = 1'b1;
    push_pass(int'(b));
    reads_seen = 0;
    cycle();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0 || busy) && guard < 3000) begin
      cycle();
      guard++;
    end
    chk({name, "_timeout"}, guard >= 3000, 0);
    chk({name, "_idle"}, {busy, read_en}, 0);
  endtask

  initial begin
    int guard;
    // Reset state
    repeat (3) cycle();
    chk("reset_outputs", {wgt_addr, read_en, size, tile_idx, tile_done, done, busy}, 0);
    rst = 1'b0;
    repeat (4) cycle();
    chk("idle_after_reset", {busy, read_en}, 0);

    // Basic pass, no stall, next_tile always high
    next_tile = 1'b1;
    do_start(AW'(0));
    drain("basic");

    // Stall for 3 cycles while the address is 5
    do_start(AW'(0));
    guard = 0;
    while (!(read_en && wgt_addr == AW'(5)) && guard < 100) begin cycle(); guard++; end
    chk("stall_reach_timeout", guard >= 100, 0);
    stall = 1'b1;
    repeat (3) begin
      #1 chk("stall_hold", {read_en, wgt_addr}, {1'b0, AW'(5)});
      cycle();
    end
    stall = 1'b0;
    drain("stall");

    // Hold next_tile low for 10 cycles in WAIT_TILE
    next_tile = 1'b0;
    do_start(AW'(0));
    guard = 0;
    while (!tile_done && guard < 100) begin cycle(); guard++; end
    chk("wait_reach_timeout", guard >= 100, 0);
    repeat (10) begin
      chk("wait_hold", {busy, read_en, size}, {1'b1, 1'b0, SW'(16)});
      cycle();
    end
    next_tile = 1'b1;
    drain("wait");

    // Address wrap from 2040 with random stall/next_tile
    rand_en = 1'b1;
    do_start(AW'(2040));
    drain("wrap");

    // start while busy is ignored
    rand_en = 1'b0;
    stall = 1'b0;
    next_tile = 1'b1;
    do_start(AW'(100));
    repeat (5) cycle();
    base_addr = AW'(500);
    start = 1'b1;
    cycle();
    start = 1'b0;
    drain("start_busy");

    // Abort while k=10
    do_start(AW'(300));
    guard = 0;
    while (reads_seen != 10 && guard < 100) begin cycle(); guard++; end
    chk("abort_reach_timeout", guard >= 100, 0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_idle", {busy, read_en, tile_done, done}, 0);
    exp_q.delete();
    ev_q.delete();
    repeat (6) cycle();
    chk("abort_stays_idle", busy, 0);

    // Random passes
    rand_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      do_start(AW'($urandom_range(0, (1 << AW) - 1)));
      drain("random");
    end
    rand_en = 1'b0;

    // Reset mid-pass
    stall = 1'b0;
    do_start(AW'(55));
    repeat (15) cycle();
    rst = 1'b1;
    #1 chk("midrun_reset", {wgt_addr, read_en, size, tile_idx, tile_done, done, busy}, 0);
    exp_q.delete();
    ev_q.delete();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (5) cycle();
    chk("reset_release_idle", {busy, read_en}, 0);

    // Single-filter instance: one tile of size 1, no WAIT_TILE
    s_base = AW'(7);
    s_start = 1'b1;
    cycle();
    s_start = 1'b0;
    for (int kk = 0; kk < DEPTH; kk++) begin
      chk("one_read", {s_read_en, s_size, s_addr}, {1'b1, SW'(1), AW'(7 + kk)});
      cycle();
    end
    chk("one_done", {s_read_en, s_tile_done, s_done}, 3'b011);
    cycle();
    chk("one_idle", {s_busy, s_tile_done, s_done}, 0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
